// File: rtl/add_issue_stage.sv
// add_issue_stage
//
// Operand issue and result capture stage wrapped around an external 16-bit
// prefix adder. Operand pairs arrive over a valid/ready stream and are
// registered in S1. S1 drives the adder terms combinationally. The adder
// result is captured in S2 together with carry/zero/overflow flags. A 16-bit
// running accumulator lets ACC ops sum a stream of words without external
// feedback.
//
// Ops: 00 ADD (a+b), 01 SUB (a-b), 10 ACC (acc+b), 11 CLR (result and acc = 0).
//
// Configuration macro:
//   ADD_ISSUE_SAT_EN - when defined, ADD/SUB/ACC results that overflow
//                      (signed) clamp to 0x7FFF / 0x8000.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand stream handshake
//   in_a, in_b, in_op          operands and opcode
//   add_term0/add_term1/add_cin  to adder inputs
//   add_sum/add_cout           from adder outputs
//   out_valid/out_ready        result stream handshake
//   out_sum, out_c/out_z/out_v result and carry/zero/signed-overflow flags
module add_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [1:0]  in_op,
    output logic [15:0] add_term0,
    output logic [15:0] add_term1,
    output logic        add_cin,
    input  logic [15:0] add_sum,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_c,
    output logic        out_z,
    output logic        out_v
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    logic        s1_valid;
    logic [15:0] s1_a;
    logic [15:0] s1_b;
    logic [1:0]  s1_op;
    logic [15:0] acc;

    logic        s2_load;
    logic        raw_v;
    logic [15:0] next_sum;
    logic        next_c;
    logic        next_z;
    logic        next_v;

    // S2 takes the S1 op whenever it is empty or its result leaves this cycle;
    // S1 can refill on the same edge it empties, giving one op per cycle.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;

    // Subtraction is a + ~b + 1; ACC substitutes the accumulator for a, so
    // in_a is ignored for ACC.
    always_comb begin
        add_term0 = s1_a;
        add_term1 = s1_b;
        add_cin   = 1'b0;
        case (s1_op)
            OP_SUB: begin
                add_term1 = ~s1_b;
                add_cin   = 1'b1;
            end
            OP_ACC: add_term0 = acc;
            OP_CLR: begin
                add_term0 = 16'h0000;
                add_term1 = 16'h0000;
            end
            default: ;
        endcase
    end

    // Signed overflow: both driven terms have the same sign and the sum does not.
    assign raw_v = (add_term0[15] == add_term1[15]) && (add_sum[15] != add_term0[15]);

    always_comb begin
        next_sum = add_sum;
        next_c   = add_cout;
        next_v   = raw_v;
`ifdef ADD_ISSUE_SAT_EN
        // Clamp toward the sign of the operands; carry stays raw.
        if (raw_v) begin
            next_sum = add_term0[15] ? 16'h8000 : 16'h7FFF;
        end
`endif
        if (s1_op == OP_CLR) begin
            next_sum = 16'h0000;
            next_c   = 1'b0;
            next_v   = 1'b0;
        end
        next_z = (next_sum == 16'h0000);
    end

    // S1 operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= 16'h0000;
            s1_b     <= 16'h0000;
            s1_op    <= OP_ADD;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= in_a;
                s1_b  <= in_b;
                s1_op <= in_op;
            end
        end
    end

    // S2 result register; out_valid stays high when a new load replaces a
    // result that was just handshaked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= 16'h0000;
            out_c     <= 1'b0;
            out_z     <= 1'b0;
            out_v     <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_sum   <= next_sum;
            out_c     <= next_c;
            out_z     <= next_z;
            out_v     <= next_v;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator updates on the edge the ACC/CLR leaves S1, so a following
    // ACC sitting in S1 already sees the new value without forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 16'h0000;
        end else if (s2_load) begin
            if (s1_op == OP_ACC) begin
                acc <= next_sum;
            end else if (s1_op == OP_CLR) begin
                acc <= 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_add_issue_stage.sv
// tb_add_issue_stage
//
// Directed testbench for add_issue_stage. Provides a behavioural 16-bit adder
// on the add_* ports, runs a table of single ops with hand-computed results,
// then hand-written sequences for back-to-back ACC, backpressure and
// mid-operation reset. Expected results follow ADD_ISSUE_SAT_EN if defined.
module tb_add_issue_stage;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [1:0]  in_op;
    logic [15:0] add_term0;
    logic [15:0] add_term1;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_c;
    logic        out_z;
    logic        out_v;

    int          tests;
    int          fails;
    logic [15:0] model_acc;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        c;
        logic        z;
        logic        v;
    } vec_t;

    vec_t vecs[12];

    add_issue_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .add_term0 (add_term0),
        .add_term1 (add_term1),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_c     (out_c),
        .out_z     (out_z),
        .out_v     (out_v)
    );

    // Behavioural stand-in for the prefix adder.
    assign {add_cout, add_sum} = {1'b0, add_term0} + {1'b0, add_term1} + {16'h0000, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input string name, input logic [1:0] op,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] sum, input logic c,
                                input logic z, input logic v);
        vec_t r;
        r.name = name;
        r.op   = op;
        r.a    = a;
        r.b    = b;
        r.sum  = sum;
        r.c    = c;
        r.z    = z;
        r.v    = v;
        return r;
    endfunction

    function automatic logic [32:0] expTerms(input logic [1:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] acc_m);
        case (op)
            OP_ADD:  return {a, b, 1'b0};
            OP_SUB:  return {a, ~b, 1'b1};
            OP_ACC:  return {acc_m, b, 1'b0};
            default: return 33'h0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [32:0] got, input logic [32:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue one op with out_ready high and S2 drained, then check terms,
    // the one-edge latency and the captured result.
    task automatic applyStimulus(input string name, input logic [1:0] op,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] e_sum, input logic e_c,
                                 input logic e_z, input logic e_v);
        int waited;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput({name, "_accept"}, 33'(in_ready), 33'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput({name, "_terms"}, {add_term0, add_term1, add_cin}, expTerms(op, a, b, model_acc));
        checkOutput({name, "_lat0"}, 33'(out_valid), 33'(0));
        @(posedge clk);
        #1;
        checkOutput({name, "_valid"}, 33'(out_valid), 33'(1));
        checkOutput({name, "_sum"}, 33'(out_sum), 33'(e_sum));
        checkOutput({name, "_c"}, 33'(out_c), 33'(e_c));
        checkOutput({name, "_z"}, 33'(out_z), 33'(e_z));
        checkOutput({name, "_v"}, 33'(out_v), 33'(e_v));
        if (op == OP_ACC) model_acc = e_sum;
        else if (op == OP_CLR) model_acc = 16'h0000;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        model_acc = 16'h0000;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 16'h0000;
        in_b      = 16'h0000;
        in_op     = OP_ADD;
        out_ready = 1'b1;

        vecs[0] = mk("add_basic", OP_ADD, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk("sub_borrow", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        vecs[2] = mk("sub_zero", OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0);
`ifdef ADD_ISSUE_SAT_EN
        vecs[3] = mk("add_ovf_pos", OP_ADD, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1);
`else
        vecs[3] = mk("add_ovf_pos", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1);
`endif
        vecs[4] = mk("add_carry", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);
`ifdef ADD_ISSUE_SAT_EN
        vecs[5] = mk("add_ovf_neg", OP_ADD, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1);
        vecs[6] = mk("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1);
`else
        vecs[5] = mk("add_ovf_neg", OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1);
        vecs[6] = mk("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b1);
`endif
        vecs[7] = mk("clr", OP_CLR, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b0);
        vecs[8] = mk("acc_first", OP_ACC, 16'hFFFF, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0);
`ifdef ADD_ISSUE_SAT_EN
        vecs[9]  = mk("acc_ovf", OP_ACC, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        vecs[10] = mk("acc_read", OP_ACC, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 1'b0);
`else
        vecs[9]  = mk("acc_ovf", OP_ACC, 16'h0000, 16'h7FFF, 16'h8004, 1'b0, 1'b0, 1'b1);
        vecs[10] = mk("acc_read", OP_ACC, 16'h0000, 16'h0000, 16'h8004, 1'b0, 1'b0, 1'b0);
`endif
        vecs[11] = mk("clr_acc", OP_CLR, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Reset state while rst_n is still low.
        #12;
        checkOutput("rst_in_ready", 33'(in_ready), 33'(1));
        checkOutput("rst_out_valid", 33'(out_valid), 33'(0));
        checkOutput("rst_terms", {add_term0, add_term1, add_cin}, 33'h0);
        checkOutput("rst_result", {13'h0, out_sum, out_c, out_z, out_v, 1'b0}, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].sum, vecs[i].c, vecs[i].z, vecs[i].v);
        end

        // Back-to-back ACC b=3 x4 after a CLR: 3, 6, 9, 12 on consecutive cycles.
        applyStimulus("b2b_clr", OP_CLR, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b_in_ready%0d", k), 33'(in_ready), 33'(1));
            if (k >= 2) begin
                checkOutput($sformatf("b2b_valid%0d", k), 33'(out_valid), 33'(1));
                checkOutput($sformatf("b2b_sum%0d", k), 33'(out_sum), 33'(3 * (k - 1)));
            end
            if (k < 4) begin
                in_valid = 1'b1;
                in_op    = OP_ACC;
                in_a     = 16'hAAAA;
                in_b     = 16'h0003;
            end else begin
                in_valid = 1'b0;
            end
        end
        model_acc = 16'h000C;
        applyStimulus("b2b_acc_read", OP_ACC, 16'h0000, 16'h0000, 16'h000C, 1'b0, 1'b0, 1'b0);

        // Backpressure: three ops offered with out_ready low.
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_ADD;
        in_a      = 16'h0001;
        in_b      = 16'h0001;
        @(negedge clk);
        checkOutput("bp_ready_second", 33'(in_ready), 33'(1));
        in_a = 16'h0002;
        in_b = 16'h0002;
        @(negedge clk);
        checkOutput("bp_ready_drop", 33'(in_ready), 33'(0));
        checkOutput("bp_valid", 33'(out_valid), 33'(1));
        checkOutput("bp_sum_first", 33'(out_sum), 33'(16'h0002));
        in_a = 16'h0003;
        in_b = 16'h0003;
        @(negedge clk);
        checkOutput("bp_hold_ready", 33'(in_ready), 33'(0));
        checkOutput("bp_hold_sum", 33'(out_sum), 33'(16'h0002));
        checkOutput("bp_hold_valid", 33'(out_valid), 33'(1));
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_drain2_valid", 33'(out_valid), 33'(1));
        checkOutput("bp_drain2_sum", 33'(out_sum), 33'(16'h0004));
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_drain3_valid", 33'(out_valid), 33'(1));
        checkOutput("bp_drain3_sum", 33'(out_sum), 33'(16'h0006));
        @(negedge clk);
        checkOutput("bp_empty", 33'(out_valid), 33'(0));

        // Reset with both stages full and acc = 0x00FF.
        applyStimulus("rst_pre_clr", OP_CLR, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        applyStimulus("rst_pre_acc", OP_ACC, 16'h0000, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_ADD;
        in_a      = 16'h0001;
        in_b      = 16'h0001;
        @(negedge clk);
        checkOutput("rst_full_ready", 33'(in_ready), 33'(0));
        checkOutput("rst_full_valid", 33'(out_valid), 33'(1));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", 33'(out_valid), 33'(0));
        checkOutput("rst_mid_ready", 33'(in_ready), 33'(1));
        checkOutput("rst_mid_terms", {add_term0, add_term1, add_cin}, 33'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        model_acc = 16'h0000;
        applyStimulus("rst_post_acc", OP_ACC, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/add_issue_stage.md
# add_issue_stage

Operand issue and result capture stage wrapped around the 16-bit prefix adder. It accepts operand pairs with an opcode over a valid/ready stream and registers them. It drives the adder's `term0`/`term1`/`cin` from that register, then captures `sum`/`cout` into an output register with status flags. It also holds a 16-bit running accumulator so streams of words can be summed without external feedback.

## Interface
- No parameters; datapath width fixed at 16 to match the adder.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operand pair present
- `in_ready`  out  1  stage can accept this cycle
- `in_a`, `in_b`  in  16  operands
- `in_op`  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
- `add_term0`, `add_term1`  out  16  to adder `term0`/`term1`
- `add_cin`  out  1  to adder `cin`
- `add_sum`  in  16  from adder `sum`
- `add_cout`  in  1  from adder `cout`
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result
- `out_sum`  out  16  result
- `out_c`, `out_z`, `out_v`  out  1 each  carry, zero, signed-overflow flags

## Operation
- Two register stages: S1 (operands, `s1_valid`) and S2 (result, `out_valid`). Accumulator `acc`, 16 bits.
- S1 term mapping, combinational from S1 regs:
  - ADD: `a`, `b`, `cin=0`.
  - SUB: `a`, `~b`, `cin=1`.
  - ACC: `acc`, `b`, `cin=0`; `in_a` ignored.
  - CLR: `0`, `0`, `cin=0`.
- `s2_load = s1_valid && (!out_valid || out_ready)`. `in_ready = !s1_valid || s2_load`.
- On `s2_load`:
  - `out_sum <= add_sum`; CLR forces 0.
  - `out_c <= add_cout`; for SUB, c=1 means no borrow.
  - `out_z <= (out_sum next == 0)`.
  - `out_v <= (t0[15]==t1[15]) && (add_sum[15]!=t0[15])`, using the driven terms.
  - CLR gives c=0, z=1, v=0.
- `acc` update on `s2_load`:
  - ACC: `acc <= next out_sum`.
  - CLR: `acc <= 0`.
  - ADD and SUB leave `acc` unchanged.
- Back-to-back ACC ops need no forwarding: `acc` updates on the same edge the ACC leaves S1.
- `out_valid` clears on `out_ready && !s2_load`, and stays set when a new load replaces the handshaked result.
- Carry out of bit 15 is not accumulated; `acc` wraps modulo 2^16.

## Timing
- Reset (async, `rst_n`=0): `s1_valid`, `out_valid`, `acc`, all S1/S2 data and flags go to 0.
  - `add_term0`/`add_term1`/`add_cin` read 0.
  - `in_ready` reads 1, since S1 is empty.
- Latency: `in_valid && in_ready` at edge N gives `out_valid`=1 after edge N+1, when S2 is free.
- Throughput: 1 op/cycle with `out_ready` held high.
- Stall: `out_ready`=0 with S2 full holds S2; a second op fills S1, then `in_ready`=0.
  - All outputs are held stable while `out_valid && !out_ready`.
- Simultaneous `out_ready` and a full S1: S2 reloads on the same edge, with no bubble.
- Reset mid-operation: in-flight ops are discarded and `acc` is cleared. No output handshake completes on the reset edge.
- Adder path is combinational S1→S2 within one cycle.

## Configuration
- `ADD_ISSUE_SAT_EN` defined: on ADD/SUB/ACC with v=1, `out_sum` and `acc` (for ACC) saturate.
  - Result is 0x7FFF if `t0[15]`=0, else 0x8000.
  - `out_v` is still reported as 1, `out_c` is raw `add_cout`, and `out_z` is computed on the saturated value.
- Undefined: wrapping two's-complement result, no clamp logic.

## Test plan
- ADD a=0x1234, b=0x0001, `out_ready`=1 → `out_valid` two edges later, sum=0x1235, c=0, z=0, v=0.
- SUB a=0x0000, b=0x0001 → sum=0xFFFF, c=0, v=0; SUB 0x0005−0x0005 → sum=0, c=1, z=1.
- ADD 0x7FFF+0x0001 → v=1; sum=0x8000 without the macro, 0x7FFF with `ADD_ISSUE_SAT_EN`.
- CLR, then ACC b=0x0003 ×4 back-to-back → sums 3, 6, 9, 12 on consecutive cycles; `acc`=0x000C.
- Backpressure: `out_ready`=0 with three ops offered → `in_ready` drops after the second is accepted. Raising `out_ready` drains results in order, one per cycle.
- Assert `rst_n`=0 with both stages full and `acc`=0x00FF → `out_valid`=0, `acc`=0, `in_ready`=1 immediately. The next ACC b=1 yields 0x0001.
